fwd_hazard_unit: RTL
====================

# fwd_hazard_unit

Operand-forwarding and load-use hazard unit for the 5-stage MIPS datapath. It tracks the destination register of every instruction in flight through EX, MEM and WB. For the two source operands in decode, it generates the 2-bit selects that drive the 5-bit/32-bit 4-to-1 operand muxes. It also raises a one-cycle stall on a load-use dependence. It sits between the ID/EX pipeline register and the operand muxes, and consumes the write address produced by the destination-register mux.

## Interface
Parameters:
- `STALL_CNT_W`, 16, width of the saturating stall-event counter.

Ports:
- `Clk`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all tracked state.
- `IdRs`  in  5  source register A of the instruction in ID.
- `IdRt`  in  5  source register B of the instruction in ID.
- `IdRsUsed`, `IdRtUsed`  in  1 each  operand actually read.
- `IdIssue`  in  1  ID instruction is valid and wants to advance to EX.
- `IdWriteEn`  in  1  ID instruction writes the register file.
- `IdWriteAddr`  in  5  destination register, as selected by the destination mux.
- `IdIsLoad`  in  1  ID instruction is a load.
- `Flush`  in  1  kill the instruction entering EX this cycle (branch/jump redirect).
- `ForwardA`, `ForwardB`  out  2 each  operand mux selects: 00 = register file, 01 = EX result, 10 = MEM result, 11 = WB result.
- `Stall`  out  1  hold PC and IF/ID, insert a bubble into EX.
- `StallCount`  out  `STALL_CNT_W`  number of cycles in which `Stall` was 1, saturating.

## Operation
- Tracking state is three slots, EX, MEM and WB. Each slot holds `{valid, addr[4:0], is_load}`.
- Slot update every cycle:
  - EX ← `{IdIssue & IdWriteEn & ~Stall & ~Flush & (IdWriteAddr != 0), IdWriteAddr, IdIsLoad}`.
  - MEM ← EX.
  - WB ← MEM.
- Writes to register 0 are never tracked, so a 0 source register always yields select 00.
- Operand A match, per slot S: `S.valid & IdRsUsed & (S.addr == IdRs)`. Operand B uses `IdRtUsed`/`IdRt` in the same way.
- Select priority, youngest first: EX match → 01; else MEM match → 10; else WB match → 11; else 00. This priority holds even when several slots match the same register.
- Load-use: `Stall = IdIssue & EX.valid & EX.is_load & (EX matches A or B)`.
  - While `Stall` is 1, both `ForwardA` and `ForwardB` are still driven by the priority rule. The ID instruction re-evaluates next cycle, after the load has moved to MEM.
- A load in MEM forwards with select 10; the MEM result bus carries the load data.
- `Flush` and `Stall` together: the bubble is inserted and the counter still increments.
- `StallCount` increments on every cycle with `Stall` = 1 and holds at all-ones.

## Timing
- `ForwardA`, `ForwardB` and `Stall` are combinational from the slot registers and the ID inputs. They are valid in the same cycle as the ID inputs, with no registered latency.
- An instruction accepted in cycle N (`IdIssue`=1, `Stall`=0, `Flush`=0) occupies EX in N+1, MEM in N+2, WB in N+3, and is gone in N+4.
- A load-use pair stalls for exactly one cycle. The dependent instruction then receives select 10.
- Reset values: all slots invalid, `ForwardA`=`ForwardB`=00, `Stall`=0, `StallCount`=0.
- Reset asserted mid-operation clears all slots immediately (asynchronously). On the first edge after deassertion, the slots reflect only the new ID inputs.

## Structure
- Shared package holds:
  - Select constants `FWD_RF`=2'b00, `FWD_EX`=2'b01, `FWD_MEM`=2'b10, `FWD_WB`=2'b11.
  - The slot struct `{valid, addr, is_load}`.
  - The register-index width, 5.
- One natural sub-module: `fwd_select`, a purely combinational block that takes one operand's register/used inputs plus the three slots and returns a 2-bit select. It is instantiated twice, once for A and once for B.
- The slot pipeline, the stall logic and the counter stay in the top module.

## Test plan
- `add $8` issued at N, then `sub` at N+1 reading `$8` as Rs → `ForwardA`=01 at N+1; an unrelated Rt gives `ForwardB`=00.
- `lw $9` at N, then `add` at N+1 reading `$9` as Rt → `Stall`=1 at N+1, `StallCount`=1. The re-evaluation at N+2 gives `ForwardB`=10, `Stall`=0.
- Writes to `$5` at N and N+1, then a reader of `$5` at N+2 → `ForwardA`=01 (EX beats MEM). With a bubble at N+1 instead → 10. With two bubbles → 11. With three bubbles → 00.
- A write to `$0`, then a reader of `$0` → selects 00, `Stall`=0. A load to `$0` followed by a use → no stall.
- `Flush` asserted with a `lw $4` issuing, then a reader of `$4` → no stall, select 00.
- Reset pulsed asynchronously while EX holds a load matching the ID operands → `Stall` drops to 0 immediately without a clock edge, selects 00, `StallCount`=0.
- Force 2^16+3 stall cycles → `StallCount` holds at 16'hFFFF.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the operand-forwarding / load-use hazard unit.
package fwd_hazard_unit_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] addr;
    logic             is_load;
  } slot_t;

  // A slot only matches a source operand that the instruction actually reads.
  function automatic logic slot_hit(input slot_t s, input logic used,
                                    input logic [REG_W-1:0] src);
    return s.valid & used & (s.addr == src);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_select.sv
// Per-operand forwarding select: youngest in-flight writer of the source register wins.
module fwd_select
  import fwd_hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  slot_t            ex_slot,
  input  slot_t            mem_slot,
  input  slot_t            wb_slot,
  output logic [1:0]       sel,
  output logic             ex_load_hit
);

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  always_comb begin
    hit_ex  = slot_hit(ex_slot, used, src);
    hit_mem = slot_hit(mem_slot, used, src);
    hit_wb  = slot_hit(wb_slot, used, src);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
    sel = FWD_RF;
    if (hit_ex)       sel = FWD_EX;
    else if (hit_mem) sel = FWD_MEM;
    else if (hit_wb)  sel = FWD_WB;

    ex_load_hit = hit_ex & ex_slot.is_load;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks destination registers through EX/MEM/WB, drives the operand-mux selects
// and raises a one-cycle load-use stall with a saturating stall-event counter.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [4:0]             IdRs,
  input  logic [4:0]             IdRt,
  input  logic                   IdRsUsed,
  input  logic                   IdRtUsed,
  input  logic                   IdIssue,
  input  logic                   IdWriteEn,
  input  logic [4:0]             IdWriteAddr,
  input  logic                   IdIsLoad,
  input  logic                   Flush,
  output logic [1:0]             ForwardA,
  output logic [1:0]             ForwardB,
  output logic                   Stall,
  output logic [STALL_CNT_W-1:0] StallCount
);

  slot_t ex_q,  ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q,  wb_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_hit_a;
  logic load_hit_b;

  fwd_select u_sel_a (
    .src         (IdRs),
    .used        (IdRsUsed),
    .ex_slot     (ex_q),
    .mem_slot    (mem_q),
    .wb_slot     (wb_q),
    .sel         (ForwardA),
    .ex_load_hit (load_hit_a)
  );

  fwd_select u_sel_b (
    .src         (IdRt),
    .used        (IdRtUsed),
    .ex_slot     (ex_q),
    .mem_slot    (mem_q),
    .wb_slot     (wb_q),
    .sel         (ForwardB),
    .ex_load_hit (load_hit_b)
  );

  always_comb begin
    Stall = IdIssue & (load_hit_a | load_hit_b);

    // Register 0 is hard-wired, so writes to it never create a dependence.
    ex_d.valid   = IdIssue & IdWriteEn & ~Stall & ~Flush & (IdWriteAddr != '0);
    ex_d.addr    = IdWriteAddr;
    ex_d.is_load = IdIsLoad;
    mem_d        = ex_q;
    wb_d         = mem_q;

    stall_cnt_d = stall_cnt_q;
    if (Stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values and the EX->MEM->WB shift is order-independent.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule
